// File: rtl/fdc_disk_if.sv
// Signal bundle between the floppy controller core, the disk responder and the backing store.
// The slave modport is the disk responder; master is the FDC/memory side.
interface fdc_disk_if;
  logic [31:0] disk_sr;
  logic [31:0] disk_cr;
  logic [7:0]  disk_data_in;
  logic        disk_data_clkin;
  logic [7:0]  disk_data_out;
  logic        disk_data_clkout;
  logic [1:0]  disk_present;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output disk_sr, disk_data_out, disk_present, mem_rdata, mem_ack,
    input  disk_cr, disk_data_in, disk_data_clkin, disk_data_clkout,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    input  disk_sr, disk_data_out, disk_present, mem_rdata, mem_ack,
    output disk_cr, disk_data_in, disk_data_clkin, disk_data_clkout,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/fdc_disk_responder.sv
// Emulated floppy drive pair: serves seek/read/write requests from an FDC core using a
// byte-wide backing store, and answers read-ID requests with a rotating sector ID.
module fdc_disk_responder #(
  parameter int unsigned TRACKS    = 40,
  parameter int unsigned SECTORS   = 9,
  parameter logic [3:0]  FORMAT_ID = 4'hC
) (
  input logic       clk,
  input logic       rst_n,
  fdc_disk_if.slave dif
);

  typedef enum logic [2:0] {
    StIdle, StSeek, StRdFetch, StRdPush, StWrPop, StWrStore, StDone
  } state_e;

  typedef enum logic [1:0] {OpSeek, OpRead, OpWrite} op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic        drv_q, drv_d;
  logic        head_q, head_d;
  logic [6:0]  cyl_q, cyl_d;
  logic [7:0]  sid_q, sid_d;
  logic        err_q, err_d;
  logic [8:0]  byte_q, byte_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  next_id_q, next_id_d;
  logic        sel_q, sel_d;
  logic [1:0]  rid_prev_q, rid_prev_d;

  logic [31:0] sr;
  logic        req_any;
  op_e         req_op;
  logic        req_drv;
  logic        sid_ok;
  logic        req_bad;
  logic        op_req;
  logic [1:0]  rid_tgl;
  logic        done;
  logic        unused_sr;

  assign sr        = dif.disk_sr;
  assign unused_sr = ^{sr[31:26], sr[19], sr[16]};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    drv_d      = drv_q;
    head_d     = head_q;
    cyl_d      = cyl_q;
    sid_d      = sid_q;
    err_d      = err_q;
    byte_d     = byte_q;
    rd_byte_d  = rd_byte_q;
    wdata_d    = wdata_q;
    next_id_d  = next_id_q;
    sel_d      = sel_q;
    rid_prev_d = sr[23:22];

    req_any = |{sr[25:24], sr[21:20], sr[18:17]};
    req_op  = OpSeek;
    req_drv = 1'b0;
    if (sr[24]) begin
      req_op = OpSeek;  req_drv = 1'b0;
    end else if (sr[25]) begin
      req_op = OpSeek;  req_drv = 1'b1;
    end else if (sr[17]) begin
      req_op = OpRead;  req_drv = 1'b0;
    end else if (sr[18]) begin
      req_op = OpRead;  req_drv = 1'b1;
    end else if (sr[20]) begin
      req_op = OpWrite; req_drv = 1'b0;
    end else if (sr[21]) begin
      req_op = OpWrite; req_drv = 1'b1;
    end

    sid_ok  = (sr[7:4] == FORMAT_ID) && (sr[3:0] != 4'd0) && (32'(sr[3:0]) <= SECTORS);
    req_bad = !dif.disk_present[req_drv] || (32'(sr[14:8]) >= TRACKS) ||
              ((req_op != OpSeek) && !sid_ok);

    // Read-ID toggles act in every state; a request latch in the same cycle wins sel.
    rid_tgl = sr[23:22] ^ rid_prev_q;
    if (rid_tgl != 2'b00) begin
      next_id_d[7:4] = FORMAT_ID;
      next_id_d[3:0] = (32'(next_id_q[3:0]) >= SECTORS) ? 4'd1 : next_id_q[3:0] + 4'd1;
      sel_d          = rid_tgl[0] ? 1'b0 : 1'b1;
    end

    unique case (op_q)
      OpSeek:  op_req = drv_q ? sr[25] : sr[24];
      OpRead:  op_req = drv_q ? sr[18] : sr[17];
      OpWrite: op_req = drv_q ? sr[21] : sr[20];
      default: op_req = 1'b0;
    endcase

    case (state_q)
      StIdle: begin
        if (req_any) begin
          op_d   = req_op;
          drv_d  = req_drv;
          sel_d  = req_drv;
          head_d = sr[15];
          cyl_d  = sr[14:8];
          sid_d  = sr[7:0];
          err_d  = req_bad;
          byte_d = 9'd0;
          if (req_op == OpSeek) begin
            state_d = StSeek;
          end else if (req_bad) begin
            state_d = StDone;
          end else begin
            state_d = (req_op == OpRead) ? StRdFetch : StWrPop;
          end
        end
      end
      StSeek: state_d = StDone;
      StRdFetch: begin
        if (dif.mem_ack) begin
          rd_byte_d = dif.mem_rdata;
          state_d   = StRdPush;
        end
      end
      StRdPush: begin
        byte_d  = byte_q + 9'd1;
        state_d = (byte_q == 9'd511) ? StDone : StRdFetch;
      end
      StWrPop: begin
        wdata_d = dif.disk_data_out;
        state_d = StWrStore;
      end
      StWrStore: begin
        if (dif.mem_ack) begin
          byte_d  = byte_q + 9'd1;
          state_d = (byte_q == 9'd511) ? StDone : StWrPop;
        end
      end
      StDone: begin
        if (!op_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OpSeek;
      drv_q      <= 1'b0;
      head_q     <= 1'b0;
      cyl_q      <= 7'd0;
      sid_q      <= 8'd0;
      err_q      <= 1'b0;
      byte_q     <= 9'd0;
      rd_byte_q  <= 8'd0;
      wdata_q    <= 8'd0;
      next_id_q  <= {FORMAT_ID, 4'h1};
      sel_q      <= 1'b0;
      // Track the live read-ID lines so release does not look like a toggle.
      rid_prev_q <= sr[23:22];
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      drv_q      <= drv_d;
      head_q     <= head_d;
      cyl_q      <= cyl_d;
      sid_q      <= sid_d;
      err_q      <= err_d;
      byte_q     <= byte_d;
      rd_byte_q  <= rd_byte_d;
      wdata_q    <= wdata_d;
      next_id_q  <= next_id_d;
      sel_q      <= sel_d;
      rid_prev_q <= rid_prev_d;
    end
  end

  assign done = (state_q == StDone);

  assign dif.disk_cr = {next_id_q, 18'd0, dif.disk_present[sel_q], done, done & err_q, 3'd0};
  assign dif.mem_addr         = {drv_q, head_q, cyl_q, sid_q[3:0] - 4'd1, byte_q};
  assign dif.mem_rd           = (state_q == StRdFetch);
  assign dif.mem_wr           = (state_q == StWrStore);
  assign dif.mem_wdata        = wdata_q;
  assign dif.disk_data_in     = rd_byte_q;
  assign dif.disk_data_clkin  = (state_q == StRdPush);
  assign dif.disk_data_clkout = (state_q == StWrPop);

endmodule
